deadlock_report_collector: RTL and testbench

//  Consumer end of the hls_deadlock monitor chain. Takes the per-dataflow-region 'block' flags

---
 rtl/deadlock_report_collector_if.sv | 10 +
 rtl/deadlock_report_collector.sv | 183 ++++++++++++++++++
 tb/tb_deadlock_report_collector.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/deadlock_report_collector_if.sv
// Report stream between the deadlock collector and the debug/host path.
interface deadlock_report_collector_if;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [31:0] rpt_data;
  logic        rpt_last;

  modport master (output rpt_valid, output rpt_data, output rpt_last, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_data, input rpt_last, output rpt_ready);
endinterface

// File: rtl/deadlock_report_collector.sv
// Debounces the per-region deadlock monitor block flags. Once a block condition has
// persisted long enough, it snapshots the raw status vectors and emits a 4-word report.
//
// state     | meaning
// S_IDLE    | waiting for any monitor block flag
// S_CONFIRM | counting consecutive cycles with any block flag high
// S_CAPTURE | one cycle: snapshot status, timestamp and lowest monitor index
// S_SEND    | streaming beats 0..3 of the report
// S_HOLD    | report done, waiting for clear to rearm
module deadlock_report_collector #(
  parameter int NUM_MON        = 4,
  parameter int CONFIRM_CYCLES = 16,
  parameter int AXIS_W         = 8,
  parameter int IDLE_W         = 19,
  parameter int BLOCK_W        = 11
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_MON-1:0]                i_mon_block,
  input  logic [AXIS_W-1:0]                 i_axis_block_sigs,
  input  logic [IDLE_W-1:0]                 i_inst_idle_sigs,
  input  logic [BLOCK_W-1:0]                i_inst_block_sigs,
  input  logic                              i_clear,
  deadlock_report_collector_if.master       rpt,
  output logic                              o_deadlock_flag,
  output logic [4:0]                        o_deadlock_idx,
  output logic [7:0]                        o_glitch_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_CONFIRM, S_CAPTURE, S_SEND, S_HOLD} state_t;

  localparam logic [15:0] CONFIRM_LAST = 16'(CONFIRM_CYCLES - 1);

  state_t               r_state, w_state_nxt;
  logic [15:0]          r_cnt, w_cnt_nxt;
  logic [1:0]           r_beat, w_beat_nxt;
  // Only the low half of the free-running timestamp ever reaches the report.
  logic [15:0]          r_ts;
  logic [AXIS_W-1:0]    r_snap_axis, w_snap_axis_nxt;
  logic [IDLE_W-1:0]    r_snap_idle, w_snap_idle_nxt;
  logic [BLOCK_W-1:0]   r_snap_blk, w_snap_blk_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_last, w_last_nxt;
  logic [31:0]          r_data, w_data_nxt;
  logic                 r_flag, w_flag_nxt;
  logic [4:0]           r_idx, w_idx_nxt;
  logic [7:0]           r_glitch, w_glitch_nxt;
  logic                 w_any_blk;
  logic                 w_xfer;
  logic [4:0]           w_low_idx;

  assign w_any_blk = |i_mon_block;
  assign w_xfer    = r_valid & rpt.rpt_ready;

  // Lowest-index monitor currently asserting block (0 if none).
  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (i_mon_block[i]) w_low_idx = 5'(i);
    end
  end

  // Free-running cycle timestamp; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 16'd1;
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_beat      <= '0;
      r_snap_axis <= '0;
      r_snap_idle <= '0;
      r_snap_blk  <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_data      <= '0;
      r_flag      <= 1'b0;
      r_idx       <= '0;
      r_glitch    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_beat      <= w_beat_nxt;
      r_snap_axis <= w_snap_axis_nxt;
      r_snap_idle <= w_snap_idle_nxt;
      r_snap_blk  <= w_snap_blk_nxt;
      r_valid     <= w_valid_nxt;
      r_last      <= w_last_nxt;
      r_data      <= w_data_nxt;
      r_flag      <= w_flag_nxt;
      r_idx       <= w_idx_nxt;
      r_glitch    <= w_glitch_nxt;
    end
  end

  // Next-state decode; clear only matters in CONFIRM and HOLD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_any_blk) w_state_nxt = S_CONFIRM;
      S_CONFIRM: begin
        if (i_clear || !w_any_blk)   w_state_nxt = S_IDLE;
        else if (r_cnt == CONFIRM_LAST) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: w_state_nxt = S_SEND;
      S_SEND:    if (w_xfer && r_beat == 2'd3) w_state_nxt = S_HOLD;
      S_HOLD:    if (i_clear) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of counters, snapshots and the registered outputs.
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_beat_nxt      = r_beat;
    w_snap_axis_nxt = r_snap_axis;
    w_snap_idle_nxt = r_snap_idle;
    w_snap_blk_nxt  = r_snap_blk;
    w_valid_nxt     = r_valid;
    w_last_nxt      = r_last;
    w_data_nxt      = r_data;
    w_flag_nxt      = r_flag;
    w_idx_nxt       = r_idx;
    w_glitch_nxt    = r_glitch;
    case (r_state)
      S_IDLE: if (w_any_blk) w_cnt_nxt = 16'd1;
      S_CONFIRM: begin
        if (i_clear) begin
          w_cnt_nxt = '0;
        end else if (!w_any_blk) begin
          w_cnt_nxt = '0;
          if (r_glitch != 8'hFF) w_glitch_nxt = r_glitch + 8'd1;
        end else if (r_cnt != CONFIRM_LAST) begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_CAPTURE: begin
        w_cnt_nxt       = '0;
        w_beat_nxt      = '0;
        w_snap_axis_nxt = i_axis_block_sigs;
        w_snap_idle_nxt = i_inst_idle_sigs;
        w_snap_blk_nxt  = i_inst_block_sigs;
        w_idx_nxt       = w_low_idx;
        w_flag_nxt      = 1'b1;
        w_valid_nxt     = 1'b1;
        w_last_nxt      = 1'b0;
        w_data_nxt      = {8'hDA, 3'b000, w_low_idx, r_ts};
      end
      S_SEND: begin
        if (w_xfer) begin
          w_beat_nxt = r_beat + 2'd1;
          case (r_beat)
            2'd0: w_data_nxt = 32'(r_snap_idle);
            2'd1: w_data_nxt = 32'(r_snap_blk);
            2'd2: begin
              w_data_nxt = 32'(r_snap_axis);
              w_last_nxt = 1'b1;
            end
            default: begin
              w_data_nxt  = '0;
              w_last_nxt  = 1'b0;
              w_valid_nxt = 1'b0;
            end
          endcase
        end
      end
      S_HOLD: if (i_clear) w_flag_nxt = 1'b0;
      default: ;
    endcase
  end

  assign rpt.rpt_valid   = r_valid;
  assign rpt.rpt_data    = r_data;
  assign rpt.rpt_last    = r_last;
  assign o_deadlock_flag = r_flag;
  assign o_deadlock_idx  = r_idx;
  assign o_glitch_cnt    = r_glitch;

endmodule

// File: tb/tb_deadlock_report_collector.sv
// Bench for deadlock_report_collector: scenario tasks with randomized monitor patterns,
// status vectors and back-pressure, checked against expectations derived from the rules.
module tb_deadlock_report_collector;
  localparam int CC = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  mon;
  logic [7:0]  axis;
  logic [18:0] idle;
  logic [10:0] blk;
  logic        clear;
  logic        flag;
  logic [4:0]  idx;
  logic [7:0]  glitch;

  int total = 0;
  int bad   = 0;
  int m_ts  = 0;
  int exp_glitch = 0;

  deadlock_report_collector_if rpt_if ();

  deadlock_report_collector #(
    .NUM_MON(4), .CONFIRM_CYCLES(CC), .AXIS_W(8), .IDLE_W(19), .BLOCK_W(11)
  ) dut (
    .clock(clock), .reset(reset), .i_mon_block(mon), .i_axis_block_sigs(axis),
    .i_inst_idle_sigs(idle), .i_inst_block_sigs(blk), .i_clear(clear), .rpt(rpt_if),
    .o_deadlock_flag(flag), .o_deadlock_idx(idx), .o_glitch_cnt(glitch)
  );

  always #5 clock = ~clock;

  // Cycle timestamp as the spec defines it: cycles since reset was last released.
  always @(posedge clock) begin
    if (reset) m_ts <= 0;
    else       m_ts <= m_ts + 1;
  end

  function automatic logic [4:0] lowest_idx(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return 5'(i);
    return 5'd0;
  endfunction

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  // Holds block flags for CC cycles then one capture cycle; returns the expected report.
  task automatic drive_confirm(input logic [3:0] pat, input bit rnd, input bit fix_idle,
                               output logic [127:0] exp_beats, output logic [4:0] exp_idx,
                               output bit early);
    logic [15:0] ts16;
    early = 1'b0;
    exp_beats = '0;
    exp_idx = '0;
    for (int i = 0; i <= CC; i++) begin
      if (!rnd || i == 0) mon = pat;
      else if (i < CC)    mon = 4'($urandom_range(1, 15));
      else                mon = 4'($urandom);
      idle = fix_idle ? 19'h7FFFF : 19'($urandom);
      blk  = 11'($urandom);
      axis = 8'($urandom);
      if (rpt_if.rpt_valid !== 1'b0 || flag !== 1'b0) early = 1'b1;
      if (i == CC) begin
        exp_idx = lowest_idx(mon);
        ts16 = m_ts[15:0];
        exp_beats = {24'b0, axis, 21'b0, blk, 13'b0, idle, 8'hDA, 3'b000, exp_idx, ts16};
      end
      step(1);
    end
    mon = pat;
  endtask

  // Accepts report beats, optionally stalling each one; records stability while stalled.
  task automatic collect(input int mode, output logic [127:0] beats, output logic [3:0] lasts,
                         output int n, output bit unstable, output bit timeout);
    int cyc;
    int stalls;
    logic [31:0] d0;
    logic l0;
    beats = '0; lasts = '0; n = 0; unstable = 1'b0; timeout = 1'b0; cyc = 0;
    while (n < 4 && !timeout) begin
      if (rpt_if.rpt_valid === 1'b1) begin
        d0 = rpt_if.rpt_data;
        l0 = rpt_if.rpt_last;
        stalls = (mode == 1) ? 5 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
        for (int s = 0; s < stalls; s++) begin
          rpt_if.rpt_ready = 1'b0;
          step(1);
          cyc++;
          if (rpt_if.rpt_valid !== 1'b1 || rpt_if.rpt_data !== d0 || rpt_if.rpt_last !== l0)
            unstable = 1'b1;
        end
        rpt_if.rpt_ready = 1'b1;
        beats[n*32 +: 32] = rpt_if.rpt_data;
        lasts[n] = rpt_if.rpt_last;
        n++;
      end else begin
        rpt_if.rpt_ready = 1'b0;
      end
      step(1);
      cyc++;
      if (cyc > 200) timeout = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mon = '0; axis = '0; idle = '0; blk = '0; clear = 1'b0;
    rpt_if.rpt_ready = 1'b0;
    step(3);
    reset = 1'b0;
    total++; if (rpt_if.rpt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rpt_if.rpt_valid); end
    total++; if (rpt_if.rpt_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", rpt_if.rpt_data); end
    total++; if (rpt_if.rpt_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", rpt_if.rpt_last); end
    total++; if (flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%b exp=0", flag); end
    total++; if (idx !== 5'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", idx); end
    total++; if (glitch !== 8'd0) begin bad++; $display("FAIL reset_glitch got=%0d exp=0", glitch); end
  endtask

  task automatic test_basic();
    logic [127:0] eb, beats; logic [4:0] ei; logic [3:0] lasts; int n; bit early, unst, to, seen;
    drive_confirm(4'b0100, 1'b0, 1'b0, eb, ei, early);
    total++; if (early) begin bad++; $display("FAIL basic_early got=valid_or_flag_before_T+%0d exp=none", CC + 1); end
    total++; if (rpt_if.rpt_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_latency got=%b exp=1", rpt_if.rpt_valid); end
    total++; if (flag !== 1'b1) begin bad++; $display("FAIL basic_flag got=%b exp=1", flag); end
    total++; if (idx !== 5'd2) begin bad++; $display("FAIL basic_idx got=%0d exp=2", idx); end
    collect(0, beats, lasts, n, unst, to);
    total++; if (n != 4 || to) begin bad++; $display("FAIL basic_beats got=%0d exp=4", n); end
    total++; if (beats !== eb) begin bad++; $display("FAIL basic_data got=%h exp=%h", beats, eb); end
    total++; if (lasts !== 4'b1000) begin bad++; $display("FAIL basic_last got=%b exp=1000", lasts); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rpt_if.rpt_valid !== 1'b0) seen = 1'b1;
      step(1);
    end
    total++; if (seen) begin bad++; $display("FAIL basic_hold_valid got=1 exp=0"); end
    total++; if (flag !== 1'b1) begin bad++; $display("FAIL basic_hold_flag got=%b exp=1", flag); end
    mon = '0; clear = 1'b1; step(1); clear = 1'b0;
    total++; if (flag !== 1'b0) begin bad++; $display("FAIL basic_clear_flag got=%b exp=0", flag); end
    total++; if (idx !== 5'd2) begin bad++; $display("FAIL basic_idx_kept got=%0d exp=2", idx); end
  endtask

  task automatic test_idx_pattern();
    logic [127:0] eb, beats; logic [4:0] ei; logic [3:0] lasts; int n; bit early, unst, to;
    drive_confirm(4'b1010, 1'b0, 1'b1, eb, ei, early);
    total++; if (idx !== 5'd1) begin bad++; $display("FAIL pat_idx got=%0d exp=1", idx); end
    collect(0, beats, lasts, n, unst, to);
    total++; if (beats[63:32] !== 32'h0007FFFF) begin bad++; $display("FAIL pat_beat1 got=%h exp=0007ffff", beats[63:32]); end
    total++; if (beats !== eb || n != 4) begin bad++; $display("FAIL pat_data got=%h exp=%h", beats, eb); end
    mon = '0; clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic test_stall();
    logic [127:0] eb, beats; logic [4:0] ei; logic [3:0] lasts; int n; bit early, unst, to, seen;
    drive_confirm(4'($urandom_range(1, 15)), 1'b1, 1'b0, eb, ei, early);
    collect(1, beats, lasts, n, unst, to);
    total++; if (unst) begin bad++; $display("FAIL stall_stable got=changed exp=stable"); end
    total++; if (n != 4 || to) begin bad++; $display("FAIL stall_count got=%0d exp=4", n); end
    total++; if (beats !== eb || lasts !== 4'b1000) begin bad++; $display("FAIL stall_data got=%h/%b exp=%h/1000", beats, lasts, eb); end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rpt_if.rpt_valid !== 1'b0) seen = 1'b1;
      step(1);
    end
    total++; if (seen) begin bad++; $display("FAIL stall_extra_transfer got=1 exp=0"); end
    mon = '0; clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] eb, beats; logic [4:0] ei; logic [3:0] lasts; int n; bit early, unst, to;
    for (int it = 0; it < 5; it++) begin
      drive_confirm(4'($urandom_range(1, 15)), 1'b1, 1'b0, eb, ei, early);
      total++; if (idx !== ei || early) begin bad++; $display("FAIL rand_idx[%0d] got=%0d exp=%0d", it, idx, ei); end
      collect(2, beats, lasts, n, unst, to);
      total++; if (beats !== eb || lasts !== 4'b1000 || n != 4 || unst) begin
        bad++; $display("FAIL rand_report[%0d] got=%h/%b exp=%h/1000", it, beats, lasts, eb);
      end
      mon = '0; step(1); clear = 1'b1; step(1); clear = 1'b0;
    end
  endtask

  task automatic test_clear();
    logic [127:0] eb, beats; logic [4:0] ei, ei1; logic [3:0] lasts; int n; bit early, unst, to, seen;
    // clear with block low in CONFIRM: not a glitch
    for (int i = 0; i < 5; i++) begin mon = 4'($urandom_range(1, 15)); step(1); end
    mon = '0; clear = 1'b1; step(1); clear = 1'b0; step(1);
    total++; if (glitch !== 8'(exp_glitch)) begin bad++; $display("FAIL clear_no_glitch got=%0d exp=%0d", glitch, exp_glitch); end
    // clear with block high restarts persistence: 5 + (CC-1) high cycles never confirm
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin mon = 4'($urandom_range(1, 15)); step(1); end
    clear = 1'b1; step(1); clear = 1'b0;
    for (int i = 0; i < CC - 1; i++) begin
      mon = 4'($urandom_range(1, 15));
      if (rpt_if.rpt_valid !== 1'b0) seen = 1'b1;
      step(1);
    end
    mon = '0; step(3);
    exp_glitch++;
    total++; if (seen || rpt_if.rpt_valid !== 1'b0) begin bad++; $display("FAIL clear_abort_valid got=1 exp=0"); end
    total++; if (glitch !== 8'(exp_glitch)) begin bad++; $display("FAIL clear_abort_glitch got=%0d exp=%0d", glitch, exp_glitch); end
    // clear pulse during SEND is ignored
    drive_confirm(4'b0110, 1'b0, 1'b0, eb, ei1, early);
    rpt_if.rpt_ready = 1'b0; clear = 1'b1; step(1); clear = 1'b0;
    total++; if (rpt_if.rpt_valid !== 1'b1) begin bad++; $display("FAIL clear_send_valid got=%b exp=1", rpt_if.rpt_valid); end
    collect(2, beats, lasts, n, unst, to);
    total++; if (beats !== eb || n != 4) begin bad++; $display("FAIL clear_send_report got=%h exp=%h", beats, eb); end
    mon = '0; step(3);
    total++; if (flag !== 1'b1) begin bad++; $display("FAIL clear_send_flag got=%b exp=1", flag); end
    clear = 1'b1; step(1); clear = 1'b0;
    total++; if (flag !== 1'b0 || idx !== ei1) begin bad++; $display("FAIL clear_hold got=%b/%0d exp=0/%0d", flag, idx, ei1); end
    // second deadlock after rearm
    drive_confirm(4'b1000, 1'b0, 1'b0, eb, ei, early);
    collect(2, beats, lasts, n, unst, to);
    total++; if (beats !== eb || n != 4 || idx !== 5'd3 || early) begin
      bad++; $display("FAIL clear_second_report got=%h idx=%0d exp=%h idx=3", beats, idx, eb);
    end
    mon = '0; clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic test_glitch();
    int len;
    bit seen;
    reset = 1'b1; step(1); reset = 1'b0;
    exp_glitch = 0;
    seen = 1'b0;
    for (int e = 0; e < 300; e++) begin
      len = (e == 0) ? CC - 1 : int'($urandom_range(1, CC - 1));
      for (int i = 0; i < len; i++) begin
        mon = 4'($urandom_range(1, 15));
        if (rpt_if.rpt_valid !== 1'b0) seen = 1'b1;
        step(1);
      end
      mon = '0;
      step(int'($urandom_range(1, 3)));
      if (exp_glitch < 255) exp_glitch++;
      if (e == 0) begin
        total++; if (glitch !== 8'd1) begin bad++; $display("FAIL glitch_first got=%0d exp=1", glitch); end
      end
      if (e == 149) begin
        total++; if (glitch !== 8'(exp_glitch)) begin bad++; $display("FAIL glitch_mid got=%0d exp=%0d", glitch, exp_glitch); end
      end
    end
    total++; if (glitch !== 8'd255) begin bad++; $display("FAIL glitch_saturate got=%0d exp=255", glitch); end
    total++; if (seen || flag !== 1'b0) begin bad++; $display("FAIL glitch_no_report got=valid exp=none"); end
  endtask

  task automatic test_reset_mid_send();
    logic [127:0] eb; logic [4:0] ei; bit early, seen;
    drive_confirm(4'b0011, 1'b0, 1'b0, eb, ei, early);
    rpt_if.rpt_ready = 1'b1; step(1); rpt_if.rpt_ready = 1'b0;
    total++; if (rpt_if.rpt_valid !== 1'b1 || rpt_if.rpt_data !== eb[63:32]) begin
      bad++; $display("FAIL rst_beat1 got=%h exp=%h", rpt_if.rpt_data, eb[63:32]);
    end
    reset = 1'b1; mon = '0; step(1); reset = 1'b0;
    total++; if (rpt_if.rpt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", rpt_if.rpt_valid); end
    total++; if (flag !== 1'b0 || glitch !== 8'd0 || idx !== 5'd0) begin
      bad++; $display("FAIL rst_regs got=%b/%0d/%0d exp=0/0/0", flag, glitch, idx);
    end
    seen = 1'b0;
    rpt_if.rpt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rpt_if.rpt_valid !== 1'b0) seen = 1'b1;
      step(1);
    end
    total++; if (seen) begin bad++; $display("FAIL rst_no_resume got=1 exp=0"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idx_pattern();
    test_stall();
    test_random();
    test_clear();
    test_glitch();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
